// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample landmarks and
// default frame geometry, common to uart_rx and the future uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int MID_START        = 7;
  localparam int LAST_OVERSAMPLE  = 15;
  localparam int DEF_N_DATA_BITS  = 8;
  localparam int DEF_N_STOP_TICKS = 16;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value sets
// the level presented downstream while in reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, LSB-first assembly, with a
// single-cycle rx_done strobe and a sticky-until-next-frame frame_error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int N_DATA_BITS  = DEF_N_DATA_BITS,
  parameter int N_STOP_TICKS = DEF_N_STOP_TICKS,
  parameter int N_TICK_BITS  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   rx,
  output logic [N_DATA_BITS-1:0] data_out,
  output logic                   rx_done,
  output logic                   frame_error,
  output logic                   busy
);

  localparam int N_BIT_W = cnt_width(N_DATA_BITS);

  localparam logic [N_TICK_BITS-1:0] S_MID  = N_TICK_BITS'(MID_START);
  localparam logic [N_TICK_BITS-1:0] S_LAST = N_TICK_BITS'(LAST_OVERSAMPLE);
  localparam logic [N_TICK_BITS-1:0] S_STOP = N_TICK_BITS'(N_STOP_TICKS - 1);
  localparam logic [N_BIT_W-1:0]     N_LAST = N_BIT_W'(N_DATA_BITS - 1);

  logic rx_s;

  uart_state_e            state_q, state_d;
  logic [N_TICK_BITS-1:0] s_q, s_d;
  logic [N_BIT_W-1:0]     n_q, n_d;
  logic [N_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [N_DATA_BITS-1:0] data_q, data_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;

    case (state_q)
      // Start detect is deliberately not tick-gated so it reacts within a clock.
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            shreg_d = {rx_s, shreg_q[N_DATA_BITS-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      // Stop level is taken at the end of the stop period, not mid-bit.
      STOP: begin
        if (tick) begin
          if (s_q == S_STOP) begin
            data_d  = shreg_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out    = data_q;
  assign rx_done     = done_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level scoreboard of expected bytes checked every
// clock, plus a fast-tick instance with two stop bits for the latency check.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int TICK_DIV = 5;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick = 1'b0;
  logic       rx;
  logic       rx2;
  logic [7:0] data_out, data_out2;
  logic       rx_done, rx_done2;
  logic       frame_error, frame_error2;
  logic       busy, busy2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       fe;
  } frame_t;

  frame_t     exp_q[$];
  frame_t     f;
  logic [7:0] exp_data = 8'h00;
  logic       exp_fe = 1'b0;
  logic       prev_done = 1'b0;
  int         done_count = 0;

  int         done2_cnt = 0;
  int         done2_cyc = 0;
  logic [7:0] done2_data = 8'h00;
  logic       done2_fe = 1'b0;

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Baud-rate generator stand-in: one-clock tick every TICK_DIV clocks.
  always @(negedge clk) begin
    tick_cnt = (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
    tick = (tick_cnt == 0);
  end

  uart_rx dut (
    .clock       (clk),
    .reset       (reset),
    .tick        (tick),
    .rx          (rx),
    .data_out    (data_out),
    .rx_done     (rx_done),
    .frame_error (frame_error),
    .busy        (busy)
  );

  uart_rx #(.N_DATA_BITS(8), .N_STOP_TICKS(32), .N_TICK_BITS(5)) dut2 (
    .clock       (clk),
    .reset       (reset),
    .tick        (1'b1),
    .rx          (rx2),
    .data_out    (data_out2),
    .rx_done     (rx_done2),
    .frame_error (frame_error2),
    .busy        (busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: outputs hold the last delivered frame; each rx_done consumes
  // the oldest expected frame.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      check("reset_data_out", data_out, 0);
      check("reset_rx_done", rx_done, 0);
      check("reset_frame_error", frame_error, 0);
      check("reset_busy", busy, 0);
      exp_data = 8'h00;
      exp_fe = 1'b0;
      exp_q.delete();
      prev_done = 1'b0;
    end else begin
      if (rx_done) begin
        done_count++;
        check("rx_done_single_cycle", prev_done, 0);
        check("rx_done_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          f = exp_q.pop_front();
          exp_data = f.data;
          exp_fe = f.fe;
        end
      end
      check("data_out", data_out, exp_data);
      check("frame_error", frame_error, exp_fe);
      prev_done = rx_done;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rx_done2) begin
      done2_cnt++;
      done2_cyc = cyc;
      done2_data = data_out2;
      done2_fe = frame_error2;
    end
  end

  task automatic drive_bit(input logic v, input int clks);
    if (clks > 0) begin
      @(negedge clk);
      rx = v;
      repeat (clks - 1) @(negedge clk);
    end
  endtask

  // A bad stop bit is held low only long enough to be sampled, so the
  // restart it causes sees a high line at its mid-start check.
  task automatic send_byte(input logic [7:0] b, input logic bad_stop, input int idle_bits);
    exp_q.push_back('{data: b, fe: bad_stop});
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CLKS);
    if (bad_stop) begin
      drive_bit(1'b0, 10 * TICK_DIV);
      drive_bit(1'b1, 6 * TICK_DIV);
    end else begin
      drive_bit(1'b1, BIT_CLKS);
    end
    drive_bit(1'b1, idle_bits * BIT_CLKS);
  endtask

  task automatic drive_fast(input logic v, input int clks);
    @(negedge clk);
    rx2 = v;
    repeat (clks - 1) @(negedge clk);
  endtask

  initial begin
    int         k;
    logic [7:0] b96;
    logic [7:0] bc3;

    reset = 1'b1;
    rx = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);

    // Single frame 0x55
    send_byte(8'h55, 1'b0, 2);
    check("t1_data_literal", data_out, 8'h55);
    check("t1_fe_literal", frame_error, 0);
    check("t1_busy_after", busy, 0);
    check("t1_done_count", done_count, 1);

    // Back-to-back frames with no idle gap
    send_byte(8'hA3, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'hFF, 1'b0, 2);
    check("t2_done_count", done_count, 4);
    check("t2_data_literal", data_out, 8'hFF);

    // Short low glitch: false start, no frame
    @(negedge clk);
    rx = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    check("glitch_busy_high", busy, 1);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("glitch_busy_low", busy, 0);
    check("glitch_done_count", done_count, 4);
    check("glitch_data_kept", data_out, 8'hFF);

    // Framing error then a good frame
    send_byte(8'h3C, 1'b1, 2);
    check("t4_data_literal", data_out, 8'h3C);
    check("t4_fe_literal", frame_error, 1);
    send_byte(8'h81, 1'b0, 2);
    check("t4_fe_cleared", frame_error, 0);
    check("t4_data2_literal", data_out, 8'h81);

    // Reset during data bit 4 of 0x96, then 0x5A
    b96 = 8'h96;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(b96[i], BIT_CLKS);
    drive_bit(b96[4], BIT_CLKS / 2);
    @(negedge clk);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    check("post_reset_busy", busy, 0);
    check("post_reset_data", data_out, 8'h00);
    check("post_reset_done", rx_done, 0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("reset_no_frame", done_count, 6);
    send_byte(8'h5A, 1'b0, 2);
    check("t5_data_literal", data_out, 8'h5A);

    // Fast mode: tick every clock, two stop bits, byte 0xC3
    bc3 = 8'hC3;
    @(negedge clk);
    rx2 = 1'b0;
    k = cyc;
    repeat (15) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_fast(bc3[i], 16);
    drive_fast(1'b1, 32);
    repeat (64) @(negedge clk);
    check("fast_done_count", done2_cnt, 1);
    check("fast_latency", done2_cyc - (k + 1), 7 + 128 + 32 + 3);
    check("fast_data", done2_data, 8'hC3);
    check("fast_fe", done2_fe, 0);
    check("fast_busy_after", busy2, 0);

    check("total_done_count", done_count, 7);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART serial receiver, 8N1 by default.
- Consumes the 16x oversampling `tick` from the baud-rate generator (tick every 163 clocks = 19200 baud at 50 MHz).
- Samples `rx` at mid-bit and assembles data LSB-first.
- Presents each received byte with a one-cycle `rx_done` strobe for downstream logic (FIFO / interface block).

Parameters:
- N_DATA_BITS, 8, number of data bits per frame.
- N_STOP_TICKS, 16, ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- N_TICK_BITS, 4, width of the oversample counter; must hold log2(max(16, N_STOP_TICKS)).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-clock-wide 16x oversample enable from the baud-rate generator.
- rx  input  1  asynchronous serial line; idles high.
- data_out  output  N_DATA_BITS  last complete byte; bit 0 is the first bit received.
- rx_done  output  1  one-clock pulse; data_out is valid in the same cycle.
- frame_error  output  1  stop-bit sample of the last frame was 0; holds until the next rx_done.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- **Reset:** state=IDLE, tick counter s=0, bit counter n=0, shift reg=0, data_out=0, rx_done=0, frame_error=0, busy=0, synchronizer flops=1 (idle line).
- **Synchronizer:** rx passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s. This adds 2 cycles of input latency.
- **Tick gating:** counters advance only in cycles where tick=1. Non-tick cycles hold all state except the IDLE start detect.
- **IDLE:**
  - rx_s==0 (any cycle, tick not required) -> START, s=0.
  - Otherwise stay in IDLE.
- **START:**
  - On tick with s==7 (mid start bit): rx_s==0 -> DATA, s=0, n=0.
  - On tick with s==7 and rx_s==1: glitch/false start -> IDLE, no rx_done.
  - Otherwise on tick: s=s+1.
- **DATA:**
  - On tick with s==15: s=0; shift reg = {rx_s, shreg[N_DATA_BITS-1:1]} (LSB-first).
  - If n==N_DATA_BITS-1 -> STOP; else n=n+1.
  - Otherwise on tick: s=s+1.
- **STOP:**
  - On tick with s==N_STOP_TICKS-1: data_out=shift reg, frame_error=~rx_s, rx_done=1 for exactly one clock, -> IDLE.
  - Otherwise on tick: s=s+1.
  - The stop-bit value is sampled at the end of the stop period, not mid-bit. This is a decided simplification.
- **Outputs:**
  - rx_done is registered and high for one clock only, even if tick is high on consecutive clocks.
  - data_out and frame_error change only at rx_done and hold between frames.
- **Framing error:** data is still delivered, with frame_error=1. If rx_s is still 0 after returning to IDLE, a new START begins immediately. A break condition therefore repeats frames of 0x00 with frame_error=1; this is the required behaviour.
- **Back-to-back frames:** a start bit immediately after the stop period is accepted with no idle gap.
- **Reset mid-frame:** returns to IDLE next clock; no rx_done; data_out is cleared to 0.
- **Frame latency:** rx_done asserts (7 + 16*N_DATA_BITS + N_STOP_TICKS) ticks after the start tick count begins, plus 2 synchronizer clocks and 1 register clock.
- **Counter wrap:** s never wraps past its terminal value in any state.

Decomposition:
- Shared package `uart_pkg`:
  - state encoding localparams IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11;
  - constants MID_START=7 and LAST_OVERSAMPLE=15;
  - default N_DATA_BITS and N_STOP_TICKS, so the future uart_tx shares them.
- One sub-module: `sync_2ff` (2-flop synchronizer, parameterised reset value, here 1), reused for other async inputs.
- The FSM plus datapath stays in uart_rx.

Test Plan:
- Bench instantiates baudrategen (N_COUNT=163) driving tick; a driver sends 0x55 at 19200 baud (52083 ns/bit) -> one rx_done pulse, data_out=0x55, frame_error=0, busy low afterward.
- Back-to-back frames 0xA3, 0x00, 0xFF with no idle gap -> three rx_done pulses in order, data_out values match, no dropped or extra pulses.
- Low glitch of 4 ticks (~13 us) on idle line -> FSM enters START, returns to IDLE at s==7, no rx_done, data_out unchanged.
- Frame 0x3C with stop bit driven 0 -> rx_done, data_out=0x3C, frame_error=1; next good frame 0x81 -> frame_error=0.
- reset asserted for 1 clock mid-way through data bit 4 of 0x96 -> all outputs return to reset values next clock; the following frame 0x5A is received correctly.
- Tick forced high every clock (fast mode), 2 stop bits (N_STOP_TICKS=32), byte 0xC3 -> rx_done exactly 7+128+32 ticks after start detect (plus pipeline), data_out=0xC3.
